mult_share_sched: RTL
=====================

Name: mult_share_sched

Overview:
Round-robin scheduler that shares one sequential shift-add multiplier (Start/Ready handshake, word1/word2 in, 2*L_word product out) among N_REQ requesters. It arbitrates requests, latches the winner's operands and drives the multiplier's Start. It then waits for completion and returns the product to the winner, tagged with the winner's index. Zero operands are resolved locally, because the multiplier never drops Ready for an empty operation.

Parameters:
L_word, 4, operand width; product is 2*L_word bits
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must be >= clog2(N_REQ)
WD_LIMIT, 2*L_word+4, watchdog limit in cycles spent in S_wait

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
req  input  N_REQ  per-requester request level
req_word1  input  N_REQ*L_word  packed multiplicands; slice i = bits [i*L_word +: L_word]
req_word2  input  N_REQ*L_word  packed multipliers, same packing
ack  output  N_REQ  one-cycle pulse: operands of requester i latched
done  output  N_REQ  one-cycle pulse: result valid for requester i
result  output  2*L_word  product of the completed job, held until next done
result_id  output  ID_W  index of the completed job, held with result
err  output  1  one-cycle pulse on watchdog expiry
mul_start  output  1  Start to multiplier
mul_word1  output  L_word  multiplicand to multiplier, registered
mul_word2  output  L_word  multiplier operand to multiplier, registered
mul_product  input  2*L_word  multiplier product
mul_ready  input  1  multiplier Ready (high when idle and not in reset)

Behaviour:
- Reset: clock is the system clock; reset is asynchronous, active-high. Reset forces:
  - state = S_idle, rr pointer = 0
  - ack, done, err, mul_start = 0
  - mul_word1, mul_word2, result, result_id = 0
- Reset mid-operation discards the job; no done and no err are emitted for it.
- States:
  - S_idle: if mul_ready=1 and any req, grant the winner, latch its operands into mul_word1/2 and its index into cur_id, and pulse ack[winner] in the cycle after the grant edge.
    - Either latched operand == 0 -> S_zero.
    - Otherwise -> S_issue.
    - If mul_ready=0, no grant is made; stay in S_idle.
  - S_issue: mul_start=1 for exactly one cycle -> S_wait.
  - S_wait: mul_start=0; count cycles.
    - If mul_ready=1, capture mul_product into result and cur_id into result_id, pulse done[cur_id] -> S_idle.
    - If the count reaches WD_LIMIT with mul_ready still 0, pulse err, leave result unchanged, no done -> S_idle.
    - The multiplier drops Ready on the same edge that leaves S_issue, so the first S_wait cycle sees mul_ready=0.
  - S_zero: result=0, result_id=cur_id, pulse done[cur_id] -> S_idle. mul_start is never asserted for this job.
- Arbitration:
  - Round-robin, scanning from rr pointer upward with wrap-around.
  - After a grant, rr = winner+1 mod N_REQ.
  - Reset priority order is 0,1,...,N_REQ-1.
- Request rules:
  - Requester holds req and operands stable until it sees ack.
  - Requester deasserts req in the cycle after ack unless it has a new job.
  - Dropping req before ack withdraws the request silently.
  - A req still high after its own done is treated as a new job.
- Output constraints:
  - At most one ack bit and one done bit are high in any cycle; ack and done are never high in the same cycle.
  - mul_word1/2 stay stable from S_issue until the job leaves S_wait.
- Latency:
  - Zero-operand job: done 2 cycles after the grant edge.
  - Non-zero job: done <= L_word+3 cycles after the grant edge.
  - Throughput is one job at a time; no new grant until the current job leaves S_wait or S_zero.
- Arithmetic: result is taken verbatim from mul_product; the scheduler never modifies it, except forcing 0 in S_zero.

Test Plan:
- Single job: req[0]=1, word1=3, word2=5 -> one ack[0] pulse, one mul_start pulse; done[0] within 7 cycles; result=15, result_id=0.
- Zero bypass: req[2]=1, word1=0, word2=9 -> ack[2], no mul_start, done[2] 2 cycles after grant edge; result=0, result_id=2.
- Round-robin: all four req high with distinct operands, (i+1)*(i+2) for requester i, re-requesting after each done -> grant order 0,1,2,3,0 and results 2,6,12,20; no requester is starved.
- Max operands: 15x15 on req[3] -> result=225 (8'hE1). Then 15x1 -> result=15.
- Watchdog: hold mul_ready=0 after mul_start (multiplier stub) -> err pulses after WD_LIMIT=12 cycles, no done, back to S_idle; the next job completes normally.
- Reset mid-job: assert reset during S_wait -> all outputs 0, no done or err. After release, req[1] 2x7 -> result=14, result_id=1.
- Exhaustive: all 256 operand pairs issued round-robin across the requesters; each result equals word1*word2, and the ack/done counts per requester match.

Source files
------------

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler that lends one sequential shift-add
// multiplier to N_REQ requesters. It picks a requester, latches its operands,
// starts the multiplier, waits for Ready, and returns the product tagged with
// the requester index. Jobs with a zero operand are answered locally, because
// the multiplier never drops Ready for them and would look like an instant hit.
module mult_share_sched #(
  parameter int L_word   = 4,
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int WD_LIMIT = 2*L_word+4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*L_word-1:0]   req_word1,
  input  logic [N_REQ*L_word-1:0]   req_word2,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          done,
  output logic [2*L_word-1:0]       result,
  output logic [ID_W-1:0]           result_id,
  output logic                      err,
  output logic                      mul_start,
  output logic [L_word-1:0]         mul_word1,
  output logic [L_word-1:0]         mul_word2,
  input  logic [2*L_word-1:0]       mul_product,
  input  logic                      mul_ready
);

  // Watchdog counter must be able to hold WD_LIMIT-1.
  localparam int CNT_W = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;

  typedef enum logic [1:0] {
    S_idle  = 2'd0,
    S_issue = 2'd1,
    S_wait  = 2'd2,
    S_zero  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_rr;
  logic [ID_W-1:0]       r_cur_id;
  logic [CNT_W-1:0]      r_wd_cnt;
  logic [N_REQ-1:0]      r_ack;
  logic [N_REQ-1:0]      r_done;
  logic                  r_err;
  logic                  r_mul_start;
  logic [L_word-1:0]     r_mul_word1;
  logic [L_word-1:0]     r_mul_word2;
  logic [2*L_word-1:0]   r_result;
  logic [ID_W-1:0]       r_result_id;

  logic [ID_W:0]         w_pick;
  logic                  w_grant_vld;
  logic [ID_W-1:0]       w_win;
  logic [ID_W-1:0]       w_rr_next;
  logic [L_word-1:0]     w_op1;
  logic [L_word-1:0]     w_op2;
  logic                  w_zero;
  logic [N_REQ-1:0]      w_ack_vec;
  logic [N_REQ-1:0]      w_done_vec;

  // Round-robin pick: scan from ptr upward with wrap. The loop runs from the
  // farthest offset down so the nearest requesting index is written last and
  // wins. Returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] reqv,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]    pick;
    logic [N_REQ-1:0] sh;
    int               idx;
    pick = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sh = reqv >> idx;
      if (sh[0]) pick = {1'b1, ID_W'(idx)};
    end
    return pick;
  endfunction

  // Arbitration and operand selection for the current request set.
  always_comb begin
    w_pick      = rr_pick(req, r_rr);
    w_grant_vld = w_pick[ID_W] & mul_ready;
    w_win       = w_pick[ID_W-1:0];
    w_rr_next   = (int'(w_win) == N_REQ-1) ? '0 : w_win + ID_W'(1);
    w_op1       = L_word'(req_word1 >> (int'(w_win) * L_word));
    w_op2       = L_word'(req_word2 >> (int'(w_win) * L_word));
    w_zero      = (w_op1 == '0) || (w_op2 == '0);
    w_ack_vec   = N_REQ'(1) << w_win;
    w_done_vec  = N_REQ'(1) << r_cur_id;
  end

  // Scheduler FSM; every output is a register so pulses last exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_idle;
      r_rr        <= '0;
      r_cur_id    <= '0;
      r_wd_cnt    <= '0;
      r_ack       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_word1 <= '0;
      r_mul_word2 <= '0;
      r_result    <= '0;
      r_result_id <= '0;
    end else begin
      r_ack       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_mul_start <= 1'b0;
      case (r_state)
        S_idle: begin
          // No grant while the multiplier is still busy (e.g. after a timeout).
          if (w_grant_vld) begin
            r_ack       <= w_ack_vec;
            r_cur_id    <= w_win;
            r_rr        <= w_rr_next;
            r_mul_word1 <= w_op1;
            r_mul_word2 <= w_op2;
            if (w_zero) begin
              r_state <= S_zero;
            end else begin
              r_state     <= S_issue;
              r_mul_start <= 1'b1;
            end
          end
        end
        S_issue: begin
          // Start is high during this state; the multiplier drops Ready on
          // the edge that leaves it.
          r_wd_cnt <= '0;
          r_state  <= S_wait;
        end
        S_wait: begin
          if (mul_ready) begin
            r_result    <= mul_product;
            r_result_id <= r_cur_id;
            r_done      <= w_done_vec;
            r_state     <= S_idle;
          end else if (r_wd_cnt == CNT_W'(WD_LIMIT-1)) begin
            // Multiplier hung: report and abandon the job, result untouched.
            r_err   <= 1'b1;
            r_state <= S_idle;
          end else begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
          end
        end
        S_zero: begin
          r_result    <= '0;
          r_result_id <= r_cur_id;
          r_done      <= w_done_vec;
          r_state     <= S_idle;
        end
        default: r_state <= S_idle;
      endcase
    end
  end

  assign ack       = r_ack;
  assign done      = r_done;
  assign err       = r_err;
  assign mul_start = r_mul_start;
  assign mul_word1 = r_mul_word1;
  assign mul_word2 = r_mul_word2;
  assign result    = r_result;
  assign result_id = r_result_id;

endmodule
